seq_stream_tx: RTL and testbench

- Serial pattern transmitter that drives the bit stream consumed by the team's "1101" sequence detector.
- Accepts a parallel word plus a repeat count, then shifts the word out MSB-first, one bit per accepted transfer, repeating it back-to-back as a continuous stream.
- An embedded reference model of the detector counts the expected "1101" hits, so benches and self-test logic can cross-check the receiving detector.

---
 rtl/seq_stream_tx.sv | 158 +++++++++++++++
 tb/tb_seq_stream_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_stream_tx.sv
// Serial "1101" pattern transmitter: shifts a loaded word out MSB-first, repeated
// back-to-back, while a reference model of the detector counts expected hits.
module seq_stream_tx #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_reps,
    output logic             dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;
    typedef enum logic [1:0] {M_S0, M_S1, M_S2, M_S3} mstate_t;

    state_t           r_state;
    state_t           w_state_nxt;
    mstate_t          r_mstate;
    mstate_t          w_mstate_nxt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_reps_left;
    logic [CNT_W-1:0] r_hit_cnt;
    logic             r_load_ready;
    logic             r_dout_valid;
    logic             r_done;

    logic             w_load_fire;
    logic             w_bit_fire;
    logic             w_last_bit;
    logic             w_last_rep;
    logic             w_bit;
    logic             w_hit;
    logic             w_load_ready_nxt;
    logic             w_dout_valid_nxt;
    logic             w_done_nxt;

    assign w_load_fire = load_valid & r_load_ready;
    assign w_bit_fire  = r_dout_valid & dout_ready;
    assign w_last_bit  = (r_bit_idx == '0);
    assign w_last_rep  = (r_reps_left <= CNT_W'(1));
    assign w_bit       = r_shift[WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_load_fire) w_state_nxt = ST_SEND;
            ST_SEND: if (w_bit_fire && w_last_bit && w_last_rep) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        w_load_ready_nxt = 1'b0;
        w_dout_valid_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        case (w_state_nxt)
            ST_IDLE: w_load_ready_nxt = 1'b1;
            ST_SEND: w_dout_valid_nxt = 1'b1;
            ST_DONE: w_done_nxt       = 1'b1;
            default: w_load_ready_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_ready <= 1'b0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_load_ready <= w_load_ready_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Reference "1101" detector model (Mealy, overlapping hits)
    always_comb begin
        w_mstate_nxt = M_S0;
        w_hit        = 1'b0;
        case (r_mstate)
            M_S0: w_mstate_nxt = w_bit ? M_S1 : M_S0;
            M_S1: w_mstate_nxt = w_bit ? M_S2 : M_S0;
            M_S2: w_mstate_nxt = w_bit ? M_S2 : M_S3;
            M_S3: begin
                w_mstate_nxt = w_bit ? M_S1 : M_S0;
                w_hit        = w_bit;
            end
            default: w_mstate_nxt = M_S0;
        endcase
    end

    // Datapath: word/shift registers, counters, model state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_reps_left <= '0;
            r_mstate    <= M_S0;
            r_hit_cnt   <= '0;
        end else if (w_load_fire) begin
            r_word      <= load_data;
            r_shift     <= load_data;
            r_bit_idx   <= IDX_W'(WIDTH - 1);
            r_reps_left <= (load_reps == '0) ? CNT_W'(1) : load_reps;
            r_mstate    <= M_S0;
            r_hit_cnt   <= '0;
        end else if (w_bit_fire) begin
            r_mstate <= w_mstate_nxt;
            if (w_hit && !(&r_hit_cnt)) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            if (w_last_bit && !w_last_rep) begin
                // Reload with no gap so the next word's MSB follows immediately
                r_shift     <= r_word;
                r_reps_left <= r_reps_left - CNT_W'(1);
                r_bit_idx   <= IDX_W'(WIDTH - 1);
            end else begin
                r_shift <= r_shift << 1;
                if (!w_last_bit) begin
                    r_bit_idx <= r_bit_idx - IDX_W'(1);
                end
            end
        end
    end

    assign load_ready = r_load_ready;
    assign dout       = r_shift[WIDTH-1];
    assign dout_valid = r_dout_valid;
    assign busy       = r_dout_valid;
    assign done       = r_done;
    assign hit_cnt    = r_hit_cnt;

endmodule

// File: tb/tb_seq_stream_tx.sv
// Directed bench for seq_stream_tx: streams hand-picked words and checks bits,
// handshake timing and the expected "1101" hit count.
module tb_seq_stream_tx;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [CNT_W-1:0] load_reps;
    logic             dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    seq_stream_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_reps  (load_reps),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .hit_cnt    (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a load and wait (bounded) for it to be taken
    task automatic do_load(input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] reps);
        int waited = 0;
        while (!load_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("load_ready_wait", 32'(load_ready), 32'd1);
        load_data  = data;
        load_reps  = reps;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    // Consume n_bits of the repeated word, optionally stalling at one bit
    task automatic run_stream(input string tag, input logic [WIDTH-1:0] word, input int n_bits,
                              input int stall_at, input int stall_len, input int exp_hits);
        for (int k = 0; k < n_bits; k++) begin
            logic exp_bit;
            exp_bit = word[WIDTH-1-(k % WIDTH)];
            if (k == stall_at) begin
                dout_ready = 1'b0;
                load_valid = 1'b1;
                load_data  = 16'hFFFF;
                load_reps  = 8'd9;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check({tag, "_stall_valid"}, 32'(dout_valid), 32'd1);
                    check({tag, "_stall_dout"}, 32'(dout), 32'(exp_bit));
                    check({tag, "_stall_no_load"}, 32'(load_ready), 32'd0);
                end
                load_valid = 1'b0;
                dout_ready = 1'b1;
            end
            check({tag, "_valid"}, 32'(dout_valid), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_bit"}, 32'(dout), 32'(exp_bit));
            check({tag, "_no_done"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_ready"}, 32'(load_ready), 32'd0);
        check({tag, "_hits"}, 32'(hit_cnt), 32'(exp_hits));
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_hits_hold"}, 32'(hit_cnt), 32'(exp_hits));
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_reps  = '0;
        dout_ready = 1'b1;
        #22;
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hits", 32'(hit_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(load_ready), 32'd1);

        // 1: single 1101 at the front
        do_load(16'hD000, 8'd1);
        run_stream("t1", 16'hD000, 16, -1, 0, 1);

        // 2: overlapping hits
        do_load(16'hDB6D, 8'd1);
        run_stream("t2", 16'hDB6D, 16, -1, 0, 5);

        // 3: hit spanning the word boundary, no gap between repeats
        do_load(16'hA003, 8'd2);
        run_stream("t3", 16'hA003, 32, -1, 0, 1);

        // 4: reps 0 acts as 1, stall on bit 2, load ignored while busy
        do_load(16'hD000, 8'd0);
        run_stream("t4", 16'hD000, 16, 2, 5, 1);

        // 5: async reset mid-stream
        do_load(16'hD000, 8'd3);
        for (int k = 0; k < 7; k++) tick();
        check("t5_pre_valid", 32'(dout_valid), 32'd1);
        check("t5_pre_hits", 32'(hit_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(dout_valid), 32'd0);
        check("t5_rst_hits", 32'(hit_cnt), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        check("t5_release_ready", 32'(load_ready), 32'd1);
        check("t5_release_done", 32'(done), 32'd0);
        do_load(16'hD000, 8'd1);
        run_stream("t5b", 16'hD000, 16, -1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
